// File: rtl/uart_pkg.sv
// uart_pkg: shared deframer state encoding, error cause codes and default start-of-frame marker.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_LEN     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CHK     = 2'd3
    } deframer_state_t;

    localparam logic [1:0] ERR_LEN = 2'b01;
    localparam logic [1:0] ERR_CHK = 2'b10;
    localparam logic [1:0] ERR_TMO = 2'b11;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_idle_timer.sv
// uart_idle_timer: idle-cycle counter with synchronous clear and a compare against a programmable limit.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : clear the count (takes priority over en)
//   en         : count this cycle
//   limit      : idle-cycle limit; 0 disables hit
//   hit        : this counting cycle is the limit-th consecutive idle cycle
module uart_idle_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic             hit
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= count + 1'b1;
    end

    // Fires on the edge where the count would reach limit, so the abort lands exactly limit idle cycles after the last pop.
    assign hit = en && !clr && (limit != '0) && (count == limit - 1'b1);

endmodule

// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: pops the UART RX FIFO, parses SOF/LEN/payload/CHK frames and streams the payload.
//   clk, rst_n               : clock, asynchronous active-low reset
//   rx_empty, r_data, rd_uart: first-word-fall-through RX FIFO interface
//   timeout_limit            : in-frame idle-cycle limit, 0 disables
//   m_data, m_valid, m_ready, m_last : payload valid/ready stream
//   frame_ok, frame_err, err_code, frame_len : per-frame report pulse, cause and length
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int                   DATA_BITS     = 8,
    parameter logic [DATA_BITS-1:0] SOF           = SOF_DEFAULT,
    parameter int                   MAX_LEN       = 16,
    parameter int                   TIMEOUT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rx_empty,
    input  logic [DATA_BITS-1:0]     r_data,
    output logic                     rd_uart,
    input  logic [TIMEOUT_WIDTH-1:0] timeout_limit,
    output logic [DATA_BITS-1:0]     m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     m_last,
    output logic                     frame_ok,
    output logic                     frame_err,
    output logic [1:0]               err_code,
    output logic [DATA_BITS-1:0]     frame_len
);

    deframer_state_t      state;
    logic [DATA_BITS-1:0] len_q;
    logic [DATA_BITS-1:0] cnt;
    logic [DATA_BITS-1:0] chk_acc;
    logic [DATA_BITS-1:0] cnt_nxt;
    logic                 out_free;
    logic                 in_frame;
    logic                 len_bad;
    logic                 hit;

    assign out_free = !m_valid || m_ready;
    assign in_frame = state != ST_HUNT;
    assign cnt_nxt  = cnt + 1'b1;
    assign len_bad  = (r_data == '0) || (r_data > MAX_LEN[DATA_BITS-1:0]);
    // Only payload pops wait for the output register; rst_n gates the pop so it reads 0 while reset is held.
    assign rd_uart  = rst_n && !rx_empty && (state != ST_PAYLOAD || out_free);

    // Counts only empty-FIFO cycles, so backpressure stalls never time out.
    uart_idle_timer #(.WIDTH(TIMEOUT_WIDTH)) u_idle_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (rd_uart || !in_frame),
        .en    (rx_empty && in_frame),
        .limit (timeout_limit),
        .hit   (hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_HUNT;
            len_q     <= '0;
            cnt       <= '0;
            chk_acc   <= '0;
            m_data    <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= '0;
            frame_len <= '0;
        end else begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            if (m_valid && m_ready) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
            end
            // hit needs rx_empty and a pop needs !rx_empty, so the two never coincide.
            if (hit) begin
                frame_err <= 1'b1;
                err_code  <= ERR_TMO;
                frame_len <= (state == ST_LEN) ? '0 : len_q;
                state     <= ST_HUNT;
            end else if (rd_uart) begin
                case (state)
                    ST_HUNT: if (r_data == SOF) state <= ST_LEN;
                    ST_LEN: begin
                        if (len_bad) begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_LEN;
                            frame_len <= r_data;
                            state     <= ST_HUNT;
                        end else begin
                            len_q   <= r_data;
                            chk_acc <= r_data;
                            cnt     <= '0;
                            state   <= ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: begin
                        m_data  <= r_data;
                        m_valid <= 1'b1;
                        m_last  <= cnt_nxt == len_q;
                        chk_acc <= chk_acc ^ r_data;
                        cnt     <= cnt_nxt;
                        if (cnt_nxt == len_q) state <= ST_CHK;
                    end
                    default: begin
                        frame_ok  <= r_data == chk_acc;
                        frame_err <= r_data != chk_acc;
                        if (r_data != chk_acc) err_code <= ERR_CHK;
                        frame_len <= len_q;
                        state     <= ST_HUNT;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb_uart_rx_deframer: frame-level reference model with directed and randomized byte streams.
module tb_uart_rx_deframer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_empty = 1'b1;
    logic [7:0]  r_data = 8'h00;
    logic        rd_uart;
    logic [15:0] timeout_limit = 16'd50;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        m_last;
    logic        frame_ok;
    logic        frame_err;
    logic [1:0]  err_code;
    logic [7:0]  frame_len;

    always #5 clk = ~clk;

    uart_rx_deframer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_empty      (rx_empty),
        .r_data        (r_data),
        .rd_uart       (rd_uart),
        .timeout_limit (timeout_limit),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_last        (m_last),
        .frame_ok      (frame_ok),
        .frame_err     (frame_err),
        .err_code      (err_code),
        .frame_len     (frame_len)
    );

    // FIFO contents, bytes waiting to arrive, expected stream {last,data} and reports {ok,code,len}.
    logic [7:0]  fifo[$];
    logic [7:0]  src[$];
    logic [7:0]  pat[$];
    logic [8:0]  exp_pay[$];
    logic [10:0] exp_rep[$];
    logic [8:0]  pay_log[$];
    logic [10:0] rep_log[$];
    int n_cmp = 0, n_fail = 0, cyc = 0, last_pop_cyc = 0, err_cyc = 0;
    int gap_max = 0, gap_cnt = 0, ready_mode = 1;
    bit popped = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: got %0h expected none", name, act);
    endtask

    task automatic cycle();
        logic [10:0] rep;
        @(negedge clk);
        cyc++;
        if (popped) void'(fifo.pop_front());
        popped = 0;
        if (gap_max == 0) begin
            while (src.size() != 0) fifo.push_back(src.pop_front());
        end else if (src.size() != 0) begin
            if (gap_cnt == 0) begin
                fifo.push_back(src.pop_front());
                gap_cnt = $urandom_range(0, gap_max);
            end else gap_cnt--;
        end
        rx_empty = fifo.size() == 0;
        r_data   = rx_empty ? 8'h00 : fifo[0];
        m_ready  = (ready_mode == 2) ? ($urandom_range(0, 3) != 0) : (ready_mode == 1);
        #1;
        if (rst_n) begin
            if (rd_uart) begin
                if (rx_empty) fail_now("pop_empty", 1);
                popped = 1;
                last_pop_cyc = cyc;
            end
            if (m_valid && m_ready) begin
                pay_log.push_back({m_last, m_data});
                if (exp_pay.size() == 0) fail_now("unexpected_payload", {m_last, m_data});
                else chk("payload", {m_last, m_data}, exp_pay.pop_front());
            end
            if (frame_ok || frame_err) begin
                rep = {frame_ok, frame_ok ? 2'b00 : err_code, frame_len};
                rep_log.push_back(rep);
                if (frame_err && err_code == 2'b11) err_cyc = cyc;
                if (exp_rep.size() == 0) fail_now("unexpected_report", rep);
                else chk("report", rep, exp_rep.pop_front());
            end
        end
    endtask

    task automatic drain(input int maxc);
        int k = 0;
        while ((src.size() != 0 || fifo.size() != 0 || exp_pay.size() != 0 ||
                exp_rep.size() != 0 || m_valid) && k < maxc) begin
            cycle();
            k++;
        end
        if (k >= maxc) fail_now("drain_timeout", exp_pay.size() + exp_rep.size());
        repeat (3) cycle();
    endtask

    task automatic load();
        foreach (pat[i]) src.push_back(pat[i]);
        pay_log = {};
        rep_log = {};
    endtask

    // Random frame: optional non-SOF garbage, then SOF, LEN, payload, XOR checksum (optionally corrupted).
    task automatic rand_frame();
        int len = $urandom_range(0, 20);
        bit bad = $urandom_range(0, 4) == 0;
        logic [7:0] b, c;
        repeat ($urandom_range(0, 3)) begin
            b = 8'($urandom);
            src.push_back(b == 8'hA5 ? 8'h00 : b);
        end
        src.push_back(8'hA5);
        src.push_back(8'(len));
        if (len == 0 || len > 16) begin
            exp_rep.push_back({1'b0, 2'b01, 8'(len)});
            return;
        end
        c = 8'(len);
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            src.push_back(b);
            c ^= b;
            exp_pay.push_back({i == len - 1, b});
        end
        src.push_back(bad ? c ^ 8'($urandom_range(1, 255)) : c);
        exp_rep.push_back(bad ? {1'b0, 2'b10, 8'(len)} : {1'b1, 2'b00, 8'(len)});
    endtask

    initial begin
        repeat (3) cycle();
        chk("reset_outputs", {rd_uart, m_valid, m_last, m_data, frame_ok, frame_err, err_code, frame_len}, 0);
        rst_n = 1'b1;
        ready_mode = 1;

        pat = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        load();
        exp_pay = '{9'h011, 9'h022, 9'h133};
        exp_rep = '{11'h403};
        drain(100);
        chk("t1_count", pay_log.size(), 3);
        chk("t1_last_byte", pay_log[2], 9'h133);
        chk("t1_report", rep_log[0], 11'h403);
        chk("t1_frame_len", frame_len, 3);

        pat = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h7E, 8'h7F};
        load();
        exp_pay = '{9'h17E};
        exp_rep = '{11'h401};
        drain(100);
        chk("t2_byte", pay_log[0], 9'h17E);

        pat = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};
        load();
        exp_pay = '{9'h010, 9'h120};
        exp_rep = '{11'h202};
        drain(100);
        chk("t3_report", rep_log[0], 11'h202);

        pat = '{8'hA5, 8'h00, 8'hA5, 8'h11, 8'hA5, 8'h01, 8'h55, 8'h54};
        load();
        exp_pay = '{9'h155};
        exp_rep = '{11'h100, 11'h111, 11'h401};
        drain(100);
        chk("t4_single_payload", pay_log.size(), 1);
        chk("t4_len_err", rep_log[1], 11'h111);

        timeout_limit = 16'd100;
        pat = '{8'hA5, 8'h04, 8'hAA};
        load();
        exp_pay = '{9'h0AA};
        exp_rep = '{11'h304};
        drain(500);
        // Error register is seen one negedge after the edge that ends the 100th idle cycle.
        chk("t5_tmo_delay", err_cyc - last_pop_cyc, 101);

        timeout_limit = 16'd0;
        pat = '{8'hA5, 8'h04, 8'hAA};
        load();
        exp_pay = '{9'h0AA, 9'h0BB, 9'h0CC, 9'h1DD};
        repeat (300) cycle();
        chk("t6_no_tmo", rep_log.size(), 0);
        pat = '{8'hBB, 8'hCC, 8'hDD, 8'h04};
        foreach (pat[i]) src.push_back(pat[i]);
        exp_rep = '{11'h404};
        drain(100);
        chk("t6_report", rep_log[0], 11'h404);

        timeout_limit = 16'd10;
        pat = '{8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
        load();
        exp_pay = '{9'h001, 9'h002, 9'h003, 9'h104};
        exp_rep = '{11'h404};
        for (int k = 0; k < 50 && !m_valid; k++) cycle();
        ready_mode = 0;
        repeat (20) begin
            cycle();
            chk("t7_stall_no_pop", rd_uart, 0);
        end
        ready_mode = 1;
        drain(100);
        chk("t7_order", pay_log[3], 9'h104);

        timeout_limit = 16'd50;
        ready_mode = 2;
        gap_max = 6;
        pay_log = {};
        rep_log = {};
        repeat (40) rand_frame();
        drain(20000);
        chk("rand_reports", rep_log.size(), 40);

        gap_max = 0;
        ready_mode = 0;
        pat = '{8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04};
        load();
        exp_pay = '{9'h001};
        repeat (6) cycle();
        chk("t8_pre_reset_valid", m_valid, 1);
        exp_pay = {};
        rst_n = 1'b0;
        #1;
        chk("t8_reset_outputs", {rd_uart, m_valid, m_last, m_data, frame_ok, frame_err, err_code, frame_len}, 0);
        fifo = {};
        src = {};
        popped = 0;
        repeat (2) cycle();
        rst_n = 1'b1;
        ready_mode = 1;
        pat = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        load();
        exp_pay = '{9'h011, 9'h022, 9'h133};
        exp_rep = '{11'h403};
        drain(100);
        chk("t8_recover", rep_log.size(), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
